// File: rtl/alu_mdu.sv
// ALU with MIPS-style aluop/funct decode plus an iterative unsigned multiply/divide unit and HI/LO.
// Define ALU_DIV_EN to build the restoring divider; otherwise divu decodes as illegal.
module alu_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef ALU_DIV_EN
    localparam logic [1:0] ST_DIV  = 2'd2;
`endif

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_MULTU = 4'd7;
    localparam logic [3:0] OP_MFHI  = 4'd8;
    localparam logic [3:0] OP_MFLO  = 4'd9;
    localparam logic [3:0] OP_ILL   = 4'd10;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'd11;
`endif

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [3:0]       op;
    logic [WIDTH-1:0] alu_res;
    logic             last_iter;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    always_comb begin
        op = OP_ILL;
        unique case (aluop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b011001: op = OP_MULTU;
`ifdef ALU_DIV_EN
                    6'b011011: op = OP_DIVU;
`endif
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    default:   op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Shift-add: work_lo holds the multiplier, consumed LSB first; product bits shift into it.
    always_comb begin
        mul_sum     = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end

`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;

    // Restoring step: work_hi is the partial remainder, work_lo the dividend/quotient.
    always_comb begin
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (!div_diff[WIDTH]) begin
            div_rem_next = div_diff[WIDTH-1:0];
            div_quo_next = {work_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_next = div_shift[WIDTH-1:0];
            div_quo_next = {work_lo_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opb_d     = opb_q;
        result_d  = result_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU: begin
                            state_d   = ST_MUL;
                            cnt_d     = '0;
                            work_hi_d = '0;
                            work_lo_d = a;
                            opb_d     = b;
                        end
`ifdef ALU_DIV_EN
                        OP_DIVU: begin
                            state_d   = ST_DIV;
                            cnt_d     = '0;
                            work_hi_d = '0;
                            work_lo_d = a;
                            opb_d     = b;
                        end
`endif
                        default: begin
                            result_d  = alu_res;
                            zero_d    = (alu_res == '0);
                            done_d    = 1'b1;
                            illegal_d = (op == OP_ILL);
                        end
                    endcase
                end
            end
            ST_MUL: begin
                work_hi_d = mul_hi_next;
                work_lo_d = mul_lo_next;
                cnt_d     = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    hi_d     = mul_hi_next;
                    lo_d     = mul_lo_next;
                    result_d = mul_lo_next;
                    zero_d   = (mul_lo_next == '0);
                    done_d   = 1'b1;
                end
            end
`ifdef ALU_DIV_EN
            ST_DIV: begin
                work_hi_d = div_rem_next;
                work_lo_d = div_quo_next;
                cnt_d     = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    hi_d     = div_rem_next;
                    lo_d     = div_quo_next;
                    result_d = div_quo_next;
                    zero_d   = (div_quo_next == '0);
                    done_d   = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign illegal = illegal_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
